// File: rtl/command_sequencer.sv
// Command sequencer: runs decoded SPI commands (write, read, N-beat stream read)
// as the sole master on the peripheral bus and returns read data / stream beats.
module command_sequencer #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [7:0]        instruction_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              cmd_ready_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] stream_o,
  output logic              stream_valid_o,
  input  logic              stream_ready_i,
  output logic [3:0]        status_o
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W = 8;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STREAM = 8'h03;

  typedef enum logic [1:0] {IDLE, ISSUE, S_ISSUE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                req_d, we_d, svalid_d, ready_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, result_d, stream_d;
  logic                done_d, timeout_d, illegal_d;

  logic accept_c, ack_c, expire_c;

  assign accept_c = (state_q == IDLE) && cmd_valid_i;
  assign ack_c    = bus_req_o && bus_ack_i;
  assign expire_c = bus_req_o && !bus_ack_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // State and registered outputs; reset drops every bus/stream strobe at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      to_cnt_q       <= '0;
      remaining_q    <= '0;
      cmd_ready_o    <= 1'b1;
      bus_req_o      <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_addr_o     <= '0;
      bus_wdata_o    <= '0;
      result_o       <= '0;
      stream_o       <= '0;
      stream_valid_o <= 1'b0;
      status_o       <= '0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      remaining_q    <= remaining_d;
      cmd_ready_o    <= ready_d;
      bus_req_o      <= req_d;
      bus_we_o       <= we_d;
      bus_addr_o     <= addr_d;
      bus_wdata_o    <= wdata_d;
      result_o       <= result_d;
      stream_o       <= stream_d;
      stream_valid_o <= svalid_d;
      status_o       <= {illegal_d, timeout_d, done_d, !ready_d};
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (instruction_i == OP_WRITE || instruction_i == OP_READ) begin
            state_d = ISSUE;
          end else if (instruction_i == OP_STREAM && value_i[CNT_W-1:0] != '0) begin
            state_d = S_ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ack_c || expire_c) state_d = IDLE;
      end
      S_ISSUE: begin
        if (ack_c)         state_d = S_HOLD;
        else if (expire_c) state_d = IDLE;
      end
      S_HOLD: begin
        if (stream_ready_i) state_d = (remaining_q == CNT_W'(1)) ? IDLE : S_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, datapath and status flags
  always_comb begin
    to_cnt_d    = bus_req_o ? to_cnt_q + TO_W'(1) : '0;
    remaining_d = remaining_q;
    req_d       = bus_req_o;
    we_d        = bus_we_o;
    addr_d      = bus_addr_o;
    wdata_d     = bus_wdata_o;
    result_d    = result_o;
    stream_d    = stream_o;
    svalid_d    = stream_valid_o;
    done_d      = status_o[1];
    timeout_d   = status_o[2];
    illegal_d   = status_o[3];
    ready_d     = (state_d == IDLE);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          illegal_d   = 1'b0;
          addr_d      = address_i;
          wdata_d     = value_i;
          remaining_d = value_i[CNT_W-1:0];
          to_cnt_d    = '0;
          case (instruction_i)
            OP_NOP:   done_d = 1'b1;
            OP_WRITE: begin req_d = 1'b1; we_d = 1'b1; end
            OP_READ:  begin req_d = 1'b1; we_d = 1'b0; end
            OP_STREAM: begin
              we_d = 1'b0;
              if (value_i[CNT_W-1:0] == '0) done_d = 1'b1;
              else                          req_d  = 1'b1;
            end
            default:  illegal_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        if (ack_c) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          if (!bus_we_o) result_d = bus_rdata_i;
        end else if (expire_c) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ack_c) begin
          req_d    = 1'b0;
          stream_d = bus_rdata_i;
          svalid_d = 1'b1;
        end else if (expire_c) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (stream_ready_i) begin
          svalid_d    = 1'b0;
          remaining_d = remaining_q - CNT_W'(1);
          addr_d      = bus_addr_o + ADDR_W'(4);
          if (remaining_q == CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            req_d    = 1'b1;
            to_cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Self-checking bench for command_sequencer: bus responder and stream consumer
// pop expected transactions/beats from scoreboards filled by the stimulus.
module tb_command_sequencer;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_txn_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic [7:0]        instruction_i;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] value_i;
  logic              cmd_ready_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i = 1'b0;
  logic [DATA_W-1:0] bus_rdata_i = '0;
  logic [DATA_W-1:0] result_o;
  logic [DATA_W-1:0] stream_o;
  logic              stream_valid_o;
  logic              stream_ready_i = 1'b0;
  logic [3:0]        status_o;

  int n_checks = 0;
  int n_errors = 0;

  bus_txn_t          exp_bus_q[$];
  logic [DATA_W-1:0] rdata_q[$];
  logic [DATA_W-1:0] exp_beat_q[$];

  int ack_delay    = 1;
  int stall        = 5;
  int beats_taken  = 0;
  int stray_req    = 0;
  int stray_served = 0;
  bit in_stream    = 1'b0;

  command_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .instruction_i  (instruction_i),
    .address_i      (address_i),
    .value_i        (value_i),
    .cmd_ready_o    (cmd_ready_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i),
    .result_o       (result_o),
    .stream_o       (stream_o),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .status_o       (status_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus responder: checks each request against the scoreboard, acks after ack_delay cycles
  int       held = 0;
  bit       req_seen = 1'b0;
  bus_txn_t rsp_exp;
  always begin
    @(posedge clk); #1;
    if (rst_i) begin
      bus_ack_i = 1'b0;
      req_seen  = 1'b0;
      held      = 0;
    end else if (bus_ack_i) begin
      bus_ack_i = 1'b0;
      req_seen  = 1'b0;
      check("req_drop_after_ack", 64'(bus_req_o), 64'd0);
      if (!in_stream) check("ready_after_ack", 64'(cmd_ready_o), 64'd1);
    end else if (bus_req_o) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        held     = 0;
        if (exp_bus_q.size() == 0) begin
          check("unexpected_req", 64'd1, 64'd0);
        end else begin
          rsp_exp = exp_bus_q.pop_front();
          check("bus_we", 64'(bus_we_o), 64'(rsp_exp.we));
          check("bus_addr", 64'(bus_addr_o), 64'(rsp_exp.addr));
          if (rsp_exp.we) check("bus_wdata", 64'(bus_wdata_o), 64'(rsp_exp.wdata));
        end
      end
      held++;
      if (ack_delay != 0 && held == ack_delay) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = (rdata_q.size() != 0) ? rdata_q.pop_front() : '0;
      end
    end else begin
      if (req_seen) begin
        check("timeout_len", 64'(held), 64'(TO));
        req_seen = 1'b0;
      end
      if (stray_req != stray_served) begin
        stray_served++;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
      end
    end
  end

  // Stream consumer: holds ready low for 'stall' cycles per beat, checks beat order
  int                vcnt = 0;
  logic [DATA_W-1:0] beat_exp;
  always begin
    @(posedge clk); #1;
    if (rst_i) begin
      stream_ready_i = 1'b0;
      vcnt           = 0;
    end else begin
      if (in_stream) check("req_valid_overlap", 64'(bus_req_o & stream_valid_o), 64'd0);
      if (stream_ready_i) begin
        stream_ready_i = 1'b0;
        beats_taken++;
        check("valid_drop", 64'(stream_valid_o), 64'd0);
      end else if (stream_valid_o) begin
        vcnt++;
        if (vcnt == stall) begin
          vcnt = 0;
          if (exp_beat_q.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            beat_exp = exp_beat_q.pop_front();
            check("stream_beat", 64'(stream_o), 64'(beat_exp));
          end
          stream_ready_i = 1'b1;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] v);
    @(negedge clk);
    cmd_valid_i   = 1'b1;
    instruction_i = op;
    address_i     = a;
    value_i       = v;
    @(negedge clk);
    cmd_valid_i   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!cmd_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(cmd_ready_o), 64'd1);
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_bus_q"}, 64'(exp_bus_q.size()), 64'd0);
    check({tag, "_beat_q"}, 64'(exp_beat_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    rst_i         = 1'b1;
    cmd_valid_i   = 1'b0;
    instruction_i = '0;
    address_i     = '0;
    value_i       = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_req", 64'(bus_req_o), 64'd0);
    check("rst_status", 64'(status_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_svalid", 64'(stream_valid_o), 64'd0);
    rst_i = 1'b0;

    // 1: WRITE, ack after 3 cycles
    ack_delay = 3;
    exp_bus_q.push_back('{we: 1'b1, addr: 24'h000010, wdata: 32'hCAFE_F00D});
    send_cmd(8'h01, 24'h000010, 32'hCAFE_F00D);
    check("t1_busy", 64'(status_o), 64'b0001);
    wait_idle("t1");
    check("t1_status", 64'(status_o), 64'b0010);
    check("t1_result", 64'(result_o), 64'd0);
    queues_empty("t1");

    // 2: READ
    ack_delay = 2;
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000020, wdata: '0});
    rdata_q.push_back(32'h1234_5678);
    send_cmd(8'h02, 24'h000020, 32'h0);
    wait_idle("t2");
    check("t2_result", 64'(result_o), 64'h1234_5678);
    check("t2_status", 64'(status_o), 64'b0010);
    queues_empty("t2");

    // 3: STREAM 3 beats across the address wrap
    in_stream = 1'b1;
    ack_delay = 2;
    stall     = 5;
    exp_bus_q.push_back('{we: 1'b0, addr: 24'hFFFFFC, wdata: '0});
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000000, wdata: '0});
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000004, wdata: '0});
    rdata_q.push_back(32'hAAAA_0001); exp_beat_q.push_back(32'hAAAA_0001);
    rdata_q.push_back(32'hBBBB_0002); exp_beat_q.push_back(32'hBBBB_0002);
    rdata_q.push_back(32'hCCCC_0003); exp_beat_q.push_back(32'hCCCC_0003);
    base = beats_taken;
    send_cmd(8'h03, 24'hFFFFFC, 32'd3);
    wait_idle("t3");
    check("t3_status", 64'(status_o), 64'b0010);
    check("t3_beats", 64'(beats_taken - base), 64'd3);
    check("t3_result", 64'(result_o), 64'h1234_5678);
    queues_empty("t3");
    in_stream = 1'b0;

    // 4: READ never acked -> timeout; then a stray ack is ignored
    ack_delay = 0;
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000030, wdata: '0});
    send_cmd(8'h02, 24'h000030, 32'h0);
    wait_idle("t4");
    check("t4_status", 64'(status_o), 64'b0100);
    check("t4_result", 64'(result_o), 64'h1234_5678);
    stray_req++;
    repeat (4) @(negedge clk);
    check("t4_stray_status", 64'(status_o), 64'b0100);
    check("t4_stray_result", 64'(result_o), 64'h1234_5678);
    check("t4_stray_ready", 64'(cmd_ready_o), 64'd1);
    queues_empty("t4");

    // 5: illegal opcode, command while busy, STREAM count 0, NOP
    send_cmd(8'h7F, 24'h000040, 32'h0);
    check("t5_illegal", 64'(status_o), 64'b1000);
    check("t5_illegal_ready", 64'(cmd_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    ack_delay = 6;
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000050, wdata: '0});
    rdata_q.push_back(32'h55AA_55AA);
    send_cmd(8'h02, 24'h000050, 32'h0);
    check("t5_busy_ready", 64'(cmd_ready_o), 64'd0);
    send_cmd(8'h01, 24'h000060, 32'h1111_2222);
    wait_idle("t5_read");
    check("t5_read_result", 64'(result_o), 64'h55AA_55AA);
    check("t5_read_status", 64'(status_o), 64'b0010);
    repeat (3) @(negedge clk);
    queues_empty("t5_drop");
    send_cmd(8'h03, 24'h000200, 32'd0);
    check("t5_s0_status", 64'(status_o), 64'b0010);
    check("t5_s0_ready", 64'(cmd_ready_o), 64'd1);
    send_cmd(8'h7F, 24'h0, 32'h0);
    send_cmd(8'h00, 24'h0, 32'h0);
    check("t5_nop_status", 64'(status_o), 64'b0010);
    repeat (3) @(negedge clk);
    queues_empty("t5");

    // 6: reset while the beat-2 request is outstanding
    in_stream = 1'b1;
    ack_delay = 4;
    for (int i = 0; i < 3; i++) begin
      exp_bus_q.push_back('{we: 1'b0, addr: 24'(24'h000100 + 4 * i), wdata: '0});
      rdata_q.push_back(32'(32'h7000_0000 + i));
      exp_beat_q.push_back(32'(32'h7000_0000 + i));
    end
    base = beats_taken;
    send_cmd(8'h03, 24'h000100, 32'd3);
    n = 0;
    while (!(beats_taken == base + 1 && bus_req_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_beat2", 64'(bus_req_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_req", 64'(bus_req_o), 64'd0);
    check("t6_rst_svalid", 64'(stream_valid_o), 64'd0);
    check("t6_rst_status", 64'(status_o), 64'd0);
    check("t6_rst_ready", 64'(cmd_ready_o), 64'd1);
    exp_bus_q.delete();
    rdata_q.delete();
    exp_beat_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_i     = 1'b0;
    in_stream = 1'b0;
    check("t6_rst_result", 64'(result_o), 64'd0);
    ack_delay = 2;
    exp_bus_q.push_back('{we: 1'b0, addr: 24'h000040, wdata: '0});
    rdata_q.push_back(32'h0BAD_F00D);
    send_cmd(8'h02, 24'h000040, 32'h0);
    wait_idle("t6");
    check("t6_result", 64'(result_o), 64'h0BAD_F00D);
    check("t6_status", 64'(status_o), 64'b0010);
    repeat (3) @(negedge clk);
    queues_empty("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
